dmem_ctrl: RTL and testbench



---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_timer.sv | 39 +++
 rtl/dmem_ctrl.sv | 155 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller.
//   ADDR_W          : RAM address width (matches register file R0)
//   DATA_W          : pixel data width
//   DEFAULT_TIMEOUT : default ack-wait bound in cycles
//   state_e         : controller state encoding
package dmem_pkg;

  localparam int unsigned ADDR_W          = 19;
  localparam int unsigned DATA_W          = 8;
  localparam int unsigned DEFAULT_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_timer.sv
// Per-access wait counter.
//   clk, RST : clock, asynchronous active-high reset
//   clr      : synchronous clear (takes priority over en)
//   en       : count enable; the count saturates at the terminal value
//   tc       : terminal count, high while count == TIMEOUT-1
module dmem_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller between the register file and image RAM.
// Latches address/write data on a request, runs a req/ack handshake with
// the RAM and returns read data with a one-cycle mem_read strobe. A wait
// timer guarantees done is always produced.
//   clk, RST            : clock, asynchronous active-high reset
//   rd_req, wr_req      : access requests, sampled only in IDLE
//   dm_addr, dm_data    : address (R0) and write data (R1[7:0])
//   busy, done, err     : status; done is a one-cycle pulse, err is sticky
//   mem_read, mem_data  : read strobe and held read data to register file
//   ram_req/we/addr/wdata : RAM request side, all registered
//   ram_rdata, ram_ack  : RAM response, valid in the ack cycle
module dmem_ctrl #(
  parameter int unsigned ADDR_W  = dmem_pkg::ADDR_W,
  parameter int unsigned DATA_W  = dmem_pkg::DATA_W,
  parameter int unsigned TIMEOUT = dmem_pkg::DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_data,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack
);

  import dmem_pkg::*;

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              abort_q, abort_d;
  logic              mem_read_q, mem_read_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              ram_req_q, ram_req_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  logic timer_clr;
  logic timer_en;
  logic timer_tc;

  // Timer runs only while waiting for an ack; it is zero on ACCESS entry.
  assign timer_clr = (state_q != ACCESS);
  assign timer_en  = (state_q == ACCESS) && !ram_ack;

  dmem_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk (clk),
    .RST (RST),
    .clr (timer_clr),
    .en  (timer_en),
    .tc  (timer_tc)
  );

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      abort_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_data_q  <= '0;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      abort_q     <= abort_d;
      mem_read_q  <= mem_read_d;
      mem_data_q  <= mem_data_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // Next-state logic. An ack in the terminal-count cycle takes precedence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rd_req || wr_req) state_d = ACCESS;
      ACCESS:  if (ram_ack || timer_tc) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, derived from the
  // next state so that every output is a flop yet aligned with its state.
  always_comb begin
    err_d       = err_q;
    abort_d     = abort_q;
    mem_data_d  = mem_data_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (rd_req || wr_req) begin
          ram_addr_d  = dm_addr;
          ram_wdata_d = dm_data;
          ram_we_d    = wr_req & ~rd_req;
          err_d       = rd_req & wr_req;
          abort_d     = 1'b0;
        end
      end
      ACCESS: begin
        if (ram_ack) begin
          if (!ram_we_q) mem_data_d = ram_rdata;
        end else if (timer_tc) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
        end
      end
      default: ;
    endcase

    busy_d     = (state_d != IDLE);
    ram_req_d  = (state_d == ACCESS);
    done_d     = (state_d == FINISH);
    mem_read_d = (state_d == FINISH) && !ram_we_d && !abort_d;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_read  = mem_read_q;
  assign mem_data  = mem_data_q;
  assign ram_req   = ram_req_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl with TIMEOUT = 8.
module tb_dmem_ctrl;

  localparam int unsigned AW = 19;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          RST = 1'b1;
  logic          rd_req = 1'b0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_data = '0;
  logic          busy, done, err, mem_read;
  logic [DW-1:0] mem_data;
  logic          ram_req, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          ram_ack = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  dmem_ctrl #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(8)
  ) dut (
    .clk      (clk),
    .RST      (RST),
    .rd_req   (rd_req),
    .wr_req   (wr_req),
    .dm_addr  (dm_addr),
    .dm_data  (dm_data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem_read (mem_read),
    .mem_data (mem_data),
    .ram_req  (ram_req),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .ram_ack  (ram_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int unsigned req_cycles;

  initial begin
    // Reset values
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_ram_req", 32'(ram_req), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_wdata", 32'(ram_wdata), 0);
    chk("rst_mem_data", 32'(mem_data), 0);
    tick();
    RST = 1'b0;
    tick();

    // Read, zero-wait RAM
    rd_req = 1'b1; dm_addr = 19'h00123;
    tick();
    rd_req = 1'b0;
    chk("rd0_req", 32'(ram_req), 1);
    chk("rd0_we", 32'(ram_we), 0);
    chk("rd0_addr", 32'(ram_addr), 32'h00123);
    chk("rd0_busy", 32'(busy), 1);
    chk("rd0_done_early", 32'(done), 0);
    ram_ack = 1'b1; ram_rdata = 8'hA5;
    tick();
    ram_ack = 1'b0; ram_rdata = 8'h00;
    chk("rd0_done", 32'(done), 1);
    chk("rd0_mem_read", 32'(mem_read), 1);
    chk("rd0_mem_data", 32'(mem_data), 32'hA5);
    chk("rd0_err", 32'(err), 0);
    chk("rd0_req_low", 32'(ram_req), 0);
    tick();
    chk("rd0_done_pulse", 32'(done), 0);
    chk("rd0_mem_read_pulse", 32'(mem_read), 0);
    chk("rd0_idle", 32'(busy), 0);

    // Ack while idle is ignored
    ram_ack = 1'b1; ram_rdata = 8'hEE;
    tick();
    ram_ack = 1'b0;
    tick();
    chk("idle_ack_data", 32'(mem_data), 32'hA5);
    chk("idle_ack_done", 32'(done), 0);

    // Write, ack in the 5th ACCESS cycle; register file changes mid-access
    wr_req = 1'b1; dm_addr = 19'h7FFFF; dm_data = 8'h3C;
    tick();
    wr_req = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      chk("wr_req", 32'(ram_req), 1);
      chk("wr_we", 32'(ram_we), 1);
      chk("wr_addr", 32'(ram_addr), 32'h7FFFF);
      chk("wr_wdata", 32'(ram_wdata), 32'h3C);
      chk("wr_no_done", 32'(done), 0);
      if (i == 2) begin
        dm_addr = 19'h00001; dm_data = 8'hFF;
      end
      if (i == 5) ram_ack = 1'b1;
      tick();
    end
    ram_ack = 1'b0;
    chk("wr_done", 32'(done), 1);
    chk("wr_mem_read", 32'(mem_read), 0);
    chk("wr_mem_data", 32'(mem_data), 32'hA5);
    chk("wr_err", 32'(err), 0);
    tick();
    chk("wr_done_pulse", 32'(done), 0);
    chk("wr_idle", 32'(busy), 0);

    // Timeout: no ack, ram_req held for exactly 8 cycles
    rd_req = 1'b1; dm_addr = 19'h00005;
    tick();
    rd_req = 1'b0;
    req_cycles = 0;
    while (ram_req && req_cycles < 20) begin
      req_cycles++;
      tick();
    end
    chk("to_req_cycles", req_cycles, 8);
    chk("to_done", 32'(done), 1);
    chk("to_err", 32'(err), 1);
    chk("to_mem_read", 32'(mem_read), 0);
    chk("to_mem_data", 32'(mem_data), 32'hA5);
    tick();
    chk("to_err_sticky", 32'(err), 1);
    chk("to_idle", 32'(busy), 0);

    // Next read clears err
    rd_req = 1'b1; dm_addr = 19'h00010;
    tick();
    rd_req = 1'b0;
    chk("clr_err", 32'(err), 0);
    ram_ack = 1'b1; ram_rdata = 8'h5A;
    tick();
    ram_ack = 1'b0;
    chk("clr_mem_data", 32'(mem_data), 32'h5A);
    chk("clr_mem_read", 32'(mem_read), 1);
    tick();

    // Ack coincident with terminal count: success, no error
    rd_req = 1'b1; dm_addr = 19'h00020;
    tick();
    rd_req = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) begin
        ram_ack = 1'b1; ram_rdata = 8'h77;
      end
      tick();
    end
    ram_ack = 1'b0;
    chk("tc_ack_done", 32'(done), 1);
    chk("tc_ack_mem_read", 32'(mem_read), 1);
    chk("tc_ack_err", 32'(err), 0);
    chk("tc_ack_mem_data", 32'(mem_data), 32'h77);
    tick();

    // Collision: read wins, err set; wr_req while busy ignored
    rd_req = 1'b1; wr_req = 1'b1; dm_addr = 19'h00042; dm_data = 8'h99;
    tick();
    rd_req = 1'b0; wr_req = 1'b0;
    chk("col_we", 32'(ram_we), 0);
    chk("col_req", 32'(ram_req), 1);
    chk("col_err", 32'(err), 1);
    wr_req = 1'b1;
    ram_ack = 1'b1; ram_rdata = 8'h11;
    tick();
    ram_ack = 1'b0; wr_req = 1'b0;
    chk("col_done", 32'(done), 1);
    chk("col_mem_read", 32'(mem_read), 1);
    chk("col_mem_data", 32'(mem_data), 32'h11);
    chk("col_err_after", 32'(err), 1);
    tick();
    chk("col_ignored_req", 32'(ram_req), 0);
    tick();
    chk("col_ignored_req2", 32'(ram_req), 0);
    chk("col_ignored_busy", 32'(busy), 0);

    // Reset two cycles into ACCESS
    rd_req = 1'b1; dm_addr = 19'h00456;
    tick();
    rd_req = 1'b0;
    tick();
    chk("mid_req_before", 32'(ram_req), 1);
    RST = 1'b1;
    #1;
    chk("mid_rst_req", 32'(ram_req), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_addr", 32'(ram_addr), 0);
    chk("mid_rst_mem_data", 32'(mem_data), 0);
    #1;
    RST = 1'b0;
    tick();
    rd_req = 1'b1; dm_addr = 19'h00099;
    tick();
    rd_req = 1'b0;
    chk("post_rst_addr", 32'(ram_addr), 32'h00099);
    ram_ack = 1'b1; ram_rdata = 8'h3E;
    tick();
    ram_ack = 1'b0;
    chk("post_rst_done", 32'(done), 1);
    chk("post_rst_mem_read", 32'(mem_read), 1);
    chk("post_rst_mem_data", 32'(mem_data), 32'h3E);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
